// File: rtl/rv_mem_arbiter.sv
// Two-port (fetch + load/store) to one-port memory arbiter. Data has priority;
// fetch starvation is bounded by MAX_DATA_RUN. Define ARB_PERF_EN for perf counters.
module rv_mem_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic [31:0] iData,
  output logic        iReady,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [2:0]  dFunc3,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWData,
  output logic [31:0] dData,
  output logic        dReady,
  output logic        memValid,
  output logic [31:0] memAddress,
  output logic [2:0]  memFunc3,
  output logic        memWrite,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn,
  input  logic        memReady,
  output logic [20:0] perfIGrants,
  output logic [20:0] perfDGrants,
  output logic [20:0] perfConflicts
);
  typedef enum logic [1:0] {IDLE, IFETCH, DATA, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  func3;
    logic        write;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  state_t     state;
  bus_req_t   bus;
  logic [3:0] data_run;
  logic       grant_d, grant_i;

  // Only meaningful while state == IDLE.
  always_comb begin
    grant_d = dReq && (!iReq || (data_run < MAX_RUN));
    grant_i = !grant_d && iReq;
  end

  assign memAddress = bus.addr;
  assign memFunc3   = bus.func3;
  assign memWrite   = bus.write;
  assign memDataOut = bus.wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus      <= '0;
      memValid <= 1'b0;
      iReady   <= 1'b0;
      dReady   <= 1'b0;
      iData    <= '0;
      dData    <= '0;
      data_run <= '0;
    end else begin
      iReady <= 1'b0;
      dReady <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= DATA;
            memValid <= 1'b1;
            bus      <= '{addr: dAddr, func3: dFunc3, write: dWrite, wdata: dWData};
            // Run length only grows while a fetch is actually being held off.
            if (iReq) data_run <= (data_run == 4'd15) ? data_run : data_run + 4'd1;
            else      data_run <= '0;
          end else if (grant_i) begin
            state    <= IFETCH;
            memValid <= 1'b1;
            bus      <= '{addr: iAddr, func3: 3'd2, write: 1'b0, wdata: 32'd0};
            data_run <= '0;
          end
        end
        IFETCH: begin
          if (memReady) begin
            iData    <= memDataIn;
            memValid <= 1'b0;
            iReady   <= 1'b1;
            state    <= RESP;
          end
        end
        DATA: begin
          if (memReady) begin
            if (!bus.write) dData <= memDataIn;
            memValid  <= 1'b0;
            bus.write <= 1'b0;
            dReady    <= 1'b1;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perfIGrants   <= '0;
      perfDGrants   <= '0;
      perfConflicts <= '0;
    end else if (state == IDLE) begin
      if (grant_i)       perfIGrants   <= perfIGrants + 21'd1;
      if (grant_d)       perfDGrants   <= perfDGrants + 21'd1;
      if (iReq && dReq)  perfConflicts <= perfConflicts + 21'd1;
    end
  end
`else
  assign perfIGrants   = '0;
  assign perfDGrants   = '0;
  assign perfConflicts = '0;
`endif

endmodule
